booth_r16_digit_seq: RTL and testbench
======================================

# booth_r16_digit_seq

Sequential radix-16 Booth recoder and multiply controller that feeds the partial-product/carry accumulator shift register. On `start` it captures the multiplier, pulses the accumulator clear, then emits one signed Booth digit in [-8, +8] per cycle, least-significant digit first. The partial-product generator consumes these digits and drives the accumulator's `pp_din`/`carry_din`. `done` is asserted in the cycle the accumulator holds the complete redundant product.

## Interface
- `WIDTH`, from `mul_pkg`: multiplier operand width; must be a multiple of 4 and at least 8.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a multiply; honoured only while `ready`=1.
- `multiplier`  in  WIDTH  multiplier operand, sampled with `start`.
- `is_signed`  in  1  1 = two's-complement operand, 0 = unsigned; sampled with `start`.
- `flush`  in  1  synchronous abort to IDLE; takes priority over all other inputs.
- `ready`  out  1  idle and able to accept `start`.
- `acc_load`  out  1  one-cycle clear to the accumulator's `load` input.
- `digit_valid`  out  1  digit outputs are meaningful this cycle.
- `digit_neg`  out  1  digit sign; 1 = negative. Always 0 when the digit is zero.
- `digit_mag`  out  4  digit magnitude, 0 to 8.
- `digit_zero`  out  1  digit equals 0.
- `digit_idx`  out  $clog2(WIDTH/4+1)  digit index, starting at 0.
- `digit_last`  out  1  current digit is the final one.
- `done`  out  1  one-cycle pulse: the product is complete in the accumulator.

## Operation
- **FSM states:** IDLE, LOAD, RUN, DONE.
  - IDLE → LOAD on `start`.
  - LOAD → RUN unconditionally.
  - RUN → DONE after the last digit.
  - DONE → IDLE unconditionally.
  - Any state → IDLE on `flush`.
- **Capture (IDLE with `start`):**
  - Window register ← {ext[3:0], `multiplier`, 1'b0}. The appended 0 is y[-1].
  - `ext` = 4 copies of `multiplier`[WIDTH-1] when signed, otherwise 0.
  - Latch `is_signed`.
- **Digit count (NDIG):** WIDTH/4 when signed; WIDTH/4+1 when unsigned. The extra unsigned digit is {0000, y[WIDTH-1]}, so its value is 0 or 1.
- **Recoding:** window w[4:0] = {y[4i+3:4i], y[4i-1]}. Digit = -8·w4 + 4·w3 + 2·w2 + w1 + w0.
  - Negative digits: `digit_neg`=1 and `digit_mag`=|digit|.
  - The value -8 encodes as neg=1, mag=8.
- **RUN step:** each cycle, shift the window register right by 4, filling with the sign bit when signed and with 0 when unsigned. Increment `digit_idx`.
- **Start while not ready:** `start` with `ready`=0 is ignored. Operands are not re-sampled.
- **Reset values:** `ready`=1; every other output is 0; state is IDLE; internal registers are cleared.
- **Output timing:** all outputs derive from registered state only; there are no input-to-output combinational paths. Digit outputs are forced to 0 whenever `digit_valid`=0.
- **Flush:** `flush` in any state, including together with `start`, gives `ready`=1 on the next cycle, with no `done` and no further digits. `flush` in IDLE together with `start` drops the start.
- **Reset mid-operation:** returns immediately to the reset values.

## Timing
- Cycle 0: `start` is sampled at the rising edge that ends the cycle.
- Cycle 1: `acc_load`=1 and `ready`=0.
- Cycles 2 to NDIG+1: `digit_valid`=1, with `digit_idx` running 0 to NDIG-1. `digit_last`=1 in cycle NDIG+1.
- Cycle NDIG+2: `done`=1. The accumulator has registered the last partial product.
- Cycle NDIG+3: `ready`=1. A `start` is accepted in this cycle.
- Throughput: one multiply every NDIG+3 cycles.
- Latency from `start` to `done` (WIDTH=8): 4 cycles signed, 5 cycles unsigned.

## Structure
- **`mul_pkg` additions:**
  - `NDIG_S` = WIDTH/4.
  - `NDIG_U` = WIDTH/4+1.
  - `DIG_IDX_W` = $clog2(NDIG_U).
  - `booth_digit_t` packed struct: {neg, zero, mag[3:0]}.
  - `seq_state_e` enum covering the four FSM states.
- **Sub-module:** `booth_r16_recoder`, a purely combinational 5-bit window to `booth_digit_t` decoder. It is shareable with a future parallel multiplier.

## Test plan
- WIDTH=8, signed, `multiplier`=0x7F: digits (neg=1, mag=1) then (neg=0, mag=8). `digit_last` on idx 1. `done` 4 cycles after `start`.
- Signed 0x80: digits (zero=1) then (neg=1, mag=8). Unsigned 0xFF: digits -1, 0, +1 over idx 0 to 2, with `digit_last` on idx 2.
- `acc_load` is high exactly one cycle, the cycle before the first `digit_valid`. Outputs after reset: `ready`=1, all others 0.
- `start` pulsed during RUN with a different operand: ignored; the original digit sequence completes unchanged.
- `flush` asserted in RUN at idx 0: no `done` pulse, `ready`=1 on the next cycle. A new `start` then produces a correct, complete sequence.
- `rst_n` asserted mid-RUN: all outputs return to reset values asynchronously. Back-to-back multiplies with `start` held high: a second `acc_load` arrives exactly NDIG+3 cycles after the first.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared multiplier definitions: operand width, Booth digit encoding and
// sequencer state encoding.
package mul_pkg;
    localparam int WIDTH     = 8;
    localparam int NDIG_S    = WIDTH / 4;
    localparam int NDIG_U    = WIDTH / 4 + 1;
    localparam int DIG_IDX_W = $clog2(NDIG_U);
    localparam int WIN_W     = WIDTH + 5;

    typedef struct packed {
        logic       neg;
        logic       zero;
        logic [3:0] mag;
    } booth_digit_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } seq_state_e;
endpackage

// File: rtl/booth_r16_digit_seq_if.sv
// Request / digit-stream bundle between the multiply controller and its user.
interface booth_r16_digit_seq_if;
    import mul_pkg::*;

    logic                 start;
    logic [WIDTH-1:0]     multiplier;
    logic                 is_signed;
    logic                 flush;
    logic                 ready;
    logic                 acc_load;
    logic                 digit_valid;
    logic                 digit_neg;
    logic [3:0]           digit_mag;
    logic                 digit_zero;
    logic [DIG_IDX_W-1:0] digit_idx;
    logic                 digit_last;
    logic                 done;

    modport master (
        output start, multiplier, is_signed, flush,
        input  ready, acc_load, digit_valid, digit_neg, digit_mag,
               digit_zero, digit_idx, digit_last, done
    );

    modport slave (
        input  start, multiplier, is_signed, flush,
        output ready, acc_load, digit_valid, digit_neg, digit_mag,
               digit_zero, digit_idx, digit_last, done
    );
endinterface

// File: rtl/booth_r16_recoder.sv
// Combinational radix-16 Booth recoder: 5-bit window {y[4i+3:4i], y[4i-1]}
// to a sign/magnitude digit in [-8, +8].
module booth_r16_recoder
    import mul_pkg::*;
(
    input  logic [4:0]   win,
    output booth_digit_t digit
);
    logic signed [4:0] val;
    logic signed [4:0] abs_val;

    always_comb begin
        // -8*w4 + 4*w3 + 2*w2 is twice the signed 3-bit value {w4,w3,w2}
        val = $signed({win[4], win[4], win[3], win[2], 1'b0})
            + $signed({4'b0000, win[1]})
            + $signed({4'b0000, win[0]});
        abs_val    = (val < 0) ? -val : val;
        digit.neg  = (val < 0);
        digit.zero = (val == 5'sd0);
        digit.mag  = abs_val[3:0];
    end
endmodule

// File: rtl/booth_r16_digit_seq.sv
// Sequential radix-16 Booth digit generator and accumulator controller:
// clears the accumulator, then streams one digit per cycle, LSD first.
module booth_r16_digit_seq
    import mul_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    booth_r16_digit_seq_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'(S_IDLE);
    localparam logic [1:0] ST_LOAD = 2'(S_LOAD);
    localparam logic [1:0] ST_RUN  = 2'(S_RUN);
    localparam logic [1:0] ST_DONE = 2'(S_DONE);

    logic [1:0]           state;
    logic [WIN_W-1:0]     win;
    logic                 sgn;
    logic [DIG_IDX_W-1:0] idx;
    logic [DIG_IDX_W-1:0] last_idx;
    logic                 run;
    logic                 last;
    booth_digit_t         digit;

    assign last_idx = sgn ? DIG_IDX_W'(NDIG_S - 1) : DIG_IDX_W'(NDIG_U - 1);
    assign run      = (state == ST_RUN);
    assign last     = run && (idx == last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            win   <= '0;
            sgn   <= 1'b0;
            idx   <= '0;
        end else if (bus.flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (bus.start) begin
                    // Four sign copies above the operand, y[-1]=0 below it
                    win   <= {{4{bus.is_signed & bus.multiplier[WIDTH-1]}},
                              bus.multiplier, 1'b0};
                    sgn   <= bus.is_signed;
                    idx   <= '0;
                    state <= ST_LOAD;
                end
                ST_LOAD: state <= ST_RUN;
                ST_RUN: begin
                    win <= {{4{sgn & win[WIN_W-1]}}, win[WIN_W-1:4]};
                    idx <= idx + 1'b1;
                    if (last) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    booth_r16_recoder u_recoder (
        .win   (win[4:0]),
        .digit (digit)
    );

    assign bus.ready       = (state == ST_IDLE);
    assign bus.acc_load    = (state == ST_LOAD);
    assign bus.done        = (state == ST_DONE);
    assign bus.digit_valid = run;
    assign bus.digit_neg   = run & digit.neg;
    assign bus.digit_zero  = run & digit.zero;
    assign bus.digit_mag   = run ? digit.mag : 4'd0;
    assign bus.digit_idx   = run ? idx : '0;
    assign bus.digit_last  = last;
endmodule

// File: tb/tb_booth_r16_digit_seq.sv
// Directed bench for booth_r16_digit_seq at WIDTH=8.
module tb_booth_r16_digit_seq;
    import mul_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    booth_r16_digit_seq_if bus ();

    booth_r16_digit_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observations of one multiply, cycle k relative to the start cycle (k=0)
    logic [8:0] rec [8];
    int n_dig;
    int done_cyc;
    int load_cnt;
    int load_cyc;
    int first_vld;

    // {neg, zero, mag, last, idx}
    function automatic logic [8:0] pk(input logic n, input logic z,
                                      input logic [3:0] m, input logic l,
                                      input logic [1:0] i);
        return {n, z, m, l, i};
    endfunction

    task automatic launch(input logic [WIDTH-1:0] m, input logic s);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.multiplier = m;
        bus.is_signed  = s;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.multiplier = ~m;
        bus.is_signed  = ~s;
    endtask

    // Called at the negedge of cycle 1; stops at the negedge of the done cycle.
    task automatic collect(input int poke_k, input logic [WIDTH-1:0] poke_m,
                           input logic poke_s);
        int k;
        k = 1;
        n_dig = 0; done_cyc = -1; load_cnt = 0; load_cyc = -1; first_vld = -1;
        for (int j = 0; j < 8; j++) rec[j] = '1;
        for (int t = 0; t < 16; t++) begin
            if (bus.acc_load) begin
                load_cnt++;
                load_cyc = k;
            end
            if (bus.digit_valid && n_dig < 8) begin
                if (first_vld < 0) first_vld = k;
                rec[n_dig] = {bus.digit_neg, bus.digit_zero, bus.digit_mag,
                              bus.digit_last, bus.digit_idx};
                n_dig++;
            end
            if (bus.done) begin
                done_cyc = k;
                break;
            end
            if (k == poke_k) begin
                bus.start      = 1'b1;
                bus.multiplier = poke_m;
                bus.is_signed  = poke_s;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.flush = 1'b0; bus.multiplier = '0; bus.is_signed = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", bus.ready);
        end
        checks++;
        if ({bus.acc_load, bus.digit_valid, bus.digit_neg, bus.digit_mag, bus.digit_zero,
             bus.digit_idx, bus.digit_last, bus.done} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0",
                     {bus.acc_load, bus.digit_valid, bus.digit_neg, bus.digit_mag,
                      bus.digit_zero, bus.digit_idx, bus.digit_last, bus.done});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_signed_7f;
        launch(8'h7F, 1'b1);
        collect(-1, '0, 1'b0);
        checks++;
        if (n_dig !== 2) begin errors++; $display("FAIL s7f_ndig: got %0d want 2", n_dig); end
        checks++;
        if (rec[0] !== pk(1, 0, 4'd1, 0, 2'd0)) begin
            errors++; $display("FAIL s7f_d0: got %h want %h", rec[0], pk(1, 0, 4'd1, 0, 2'd0));
        end
        checks++;
        if (rec[1] !== pk(0, 0, 4'd8, 1, 2'd1)) begin
            errors++; $display("FAIL s7f_d1: got %h want %h", rec[1], pk(0, 0, 4'd8, 1, 2'd1));
        end
        checks++;
        if (done_cyc !== 4) begin errors++; $display("FAIL s7f_done_cyc: got %0d want 4", done_cyc); end
        checks++;
        if (load_cnt !== 1 || load_cyc !== 1) begin
            errors++; $display("FAIL s7f_acc_load: got cnt=%0d cyc=%0d want cnt=1 cyc=1", load_cnt, load_cyc);
        end
        checks++;
        if (first_vld !== 2) begin errors++; $display("FAIL s7f_first_vld: got %0d want 2", first_vld); end
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL s7f_ready_after: got ready=%b done=%b want 1/0", bus.ready, bus.done);
        end
    endtask

    task automatic test_signed_80;
        launch(8'h80, 1'b1);
        collect(-1, '0, 1'b0);
        checks++;
        if (n_dig !== 2 || rec[0] !== pk(0, 1, 4'd0, 0, 2'd0) || rec[1] !== pk(1, 0, 4'd8, 1, 2'd1)) begin
            errors++;
            $display("FAIL s80_digits: got n=%0d %h %h want n=2 %h %h", n_dig, rec[0], rec[1],
                     pk(0, 1, 4'd0, 0, 2'd0), pk(1, 0, 4'd8, 1, 2'd1));
        end
        checks++;
        if (done_cyc !== 4) begin errors++; $display("FAIL s80_done_cyc: got %0d want 4", done_cyc); end
        @(negedge clk);
    endtask

    task automatic test_unsigned_ff;
        launch(8'hFF, 1'b0);
        collect(-1, '0, 1'b0);
        checks++;
        if (n_dig !== 3) begin errors++; $display("FAIL uff_ndig: got %0d want 3", n_dig); end
        checks++;
        if (rec[0] !== pk(1, 0, 4'd1, 0, 2'd0) || rec[1] !== pk(0, 1, 4'd0, 0, 2'd1)
            || rec[2] !== pk(0, 0, 4'd1, 1, 2'd2)) begin
            errors++;
            $display("FAIL uff_digits: got %h %h %h want %h %h %h", rec[0], rec[1], rec[2],
                     pk(1, 0, 4'd1, 0, 2'd0), pk(0, 1, 4'd0, 0, 2'd1), pk(0, 0, 4'd1, 1, 2'd2));
        end
        checks++;
        if (done_cyc !== 5) begin errors++; $display("FAIL uff_done_cyc: got %0d want 5", done_cyc); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        launch(8'h7F, 1'b1);
        collect(2, 8'h80, 1'b0);
        checks++;
        if (n_dig !== 2 || rec[0] !== pk(1, 0, 4'd1, 0, 2'd0) || rec[1] !== pk(0, 0, 4'd8, 1, 2'd1)) begin
            errors++;
            $display("FAIL busy_start_digits: got n=%0d %h %h want n=2 %h %h", n_dig, rec[0], rec[1],
                     pk(1, 0, 4'd1, 0, 2'd0), pk(0, 0, 4'd8, 1, 2'd1));
        end
        checks++;
        if (done_cyc !== 4 || load_cnt !== 1) begin
            errors++; $display("FAIL busy_start_timing: got done=%0d loads=%0d want 4/1", done_cyc, load_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_flush;
        int seen;
        launch(8'h7F, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.digit_valid !== 1'b1 || bus.digit_idx !== 2'd0) begin
            errors++; $display("FAIL flush_pre: got valid=%b idx=%0d want 1/0", bus.digit_valid, bus.digit_idx);
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checks++;
        if (bus.ready !== 1'b1 || bus.digit_valid !== 1'b0) begin
            errors++; $display("FAIL flush_ready: got ready=%b valid=%b want 1/0", bus.ready, bus.digit_valid);
        end
        seen = 0;
        for (int t = 0; t < 6; t++) begin
            if (bus.done || bus.digit_valid || bus.acc_load) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL flush_quiet: got %0d active cycles want 0", seen); end
        bus.start = 1'b1; bus.flush = 1'b1; bus.multiplier = 8'h7F; bus.is_signed = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        checks++;
        if (bus.ready !== 1'b1 || bus.acc_load !== 1'b0) begin
            errors++; $display("FAIL flush_drops_start: got ready=%b load=%b want 1/0", bus.ready, bus.acc_load);
        end
        launch(8'hFF, 1'b0);
        collect(-1, '0, 1'b0);
        checks++;
        if (n_dig !== 3 || rec[0] !== pk(1, 0, 4'd1, 0, 2'd0) || rec[2] !== pk(0, 0, 4'd1, 1, 2'd2)
            || done_cyc !== 5) begin
            errors++;
            $display("FAIL flush_restart: got n=%0d d0=%h d2=%h done=%0d want n=3 d0=%h d2=%h done=5",
                     n_dig, rec[0], rec[2], done_cyc, pk(1, 0, 4'd1, 0, 2'd0), pk(0, 0, 4'd1, 1, 2'd2));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        launch(8'hFF, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ready !== 1'b1 || bus.digit_valid !== 1'b0 || bus.digit_mag !== 4'd0
            || bus.digit_neg !== 1'b0 || bus.acc_load !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got ready=%b valid=%b mag=%0d neg=%b load=%b done=%b want 1/0/0/0/0/0",
                     bus.ready, bus.digit_valid, bus.digit_mag, bus.digit_neg, bus.acc_load, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1 || bus.digit_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release: got ready=%b valid=%b want 1/0", bus.ready, bus.digit_valid);
        end
    endtask

    task automatic test_back_to_back;
        int loads [4];
        int nl;
        nl = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.multiplier = 8'h7F; bus.is_signed = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (bus.acc_load && nl < 4) begin
                loads[nl] = k;
                nl++;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (nl < 2 || loads[0] !== 1 || loads[1] !== 6) begin
            errors++;
            $display("FAIL b2b_loads: got n=%0d first=%0d second=%0d want first=1 second=6",
                     nl, (nl > 0) ? loads[0] : -1, (nl > 1) ? loads[1] : -1);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: got ready=%b want 1", bus.ready); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_signed_7f();
        test_signed_80();
        test_unsigned_ff();
        test_start_ignored();
        test_flush();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
